// File: rtl/rv_instr_encoder_if.sv
// Request and instruction-memory write bus for rv_instr_encoder.
// The slave modport is the encoder's view; master is the requester/memory side.
interface rv_instr_encoder_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [2:0]        req_funct3;
  logic [6:0]        req_funct7;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [12:0]       req_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_stall;

  modport slave (
    input  req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready,
    output imem_we, imem_addr, imem_wdata,
    input  imem_stall
  );

  modport master (
    output req_valid, req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready,
    input  imem_we, imem_addr, imem_wdata,
    output imem_stall
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Encodes symbolic RV64I requests (R, ld, sd, beq) into instruction words and writes them to imem.
// Optional legality checking (beq odd offset, unknown R funct7) is enabled by RV_ENC_CHECK_EN.
module rv_instr_encoder #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 load_end,
  rv_instr_encoder_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          word_count,
  output logic                 err
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic [31:0]       fifo [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       enc;
  logic              legal;
  logic              accept, push, start_acc;
  logic              fifo_empty, wr_free, wr_done, load_w, bypass, fifo_push, fifo_pop;

  assign bus.req_ready  = (state == LOAD) && (count < DEPTH_C);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state == LOAD) || (state == FLUSH);
  assign done           = (state == DONE);

  assign accept    = bus.req_valid && bus.req_ready;
  assign push      = accept && legal;
  assign start_acc = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    enc = '0;
    case (bus.req_kind)
      2'b00: enc = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd, 7'b0110011};
      2'b01: enc = {bus.req_imm[11:0], bus.req_rs1, 3'b011, bus.req_rd, 7'b0000011};
      2'b10: enc = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b011, bus.req_imm[4:0], 7'b0100011};
      default: enc = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1, 3'b000,
                      bus.req_imm[4:1], bus.req_imm[11], 7'b1100011};
    endcase
  end

`ifdef RV_ENC_CHECK_EN
  always_comb begin
    legal = 1'b1;
    if (bus.req_kind == 2'b11 && bus.req_imm[0])
      legal = 1'b0;
    if (bus.req_kind == 2'b00 && bus.req_funct7 != 7'b0000000 && bus.req_funct7 != 7'b0100000)
      legal = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (start_acc)
      err <= 1'b0;
    else if (accept && !legal)
      err <= 1'b1;
  end
`else
  logic unused_imm0;
  assign unused_imm0 = bus.req_imm[0];
  assign legal       = 1'b1;
  assign err         = 1'b0;
`endif

  // A write is pending while stalled; otherwise the writer can take a new word this edge.
  // When the FIFO is empty the incoming word bypasses it so imem_we rises the cycle after accept.
  assign fifo_empty = (count == '0);
  assign wr_done    = we_q && !bus.imem_stall;
  assign wr_free    = !we_q || !bus.imem_stall;
  assign load_w     = wr_free && (!fifo_empty || push);
  assign bypass     = push && fifo_empty && wr_free;
  assign fifo_push  = push && !bypass;
  assign fifo_pop   = wr_free && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (load_end) state_n = FLUSH;
      FLUSH:   if (fifo_empty && !we_q) state_n = DONE;
      DONE:    if (start) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_push)
      fifo[wptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      word_count <= '0;
    end else begin
      if (fifo_push)
        wptr <= wptr + 1'b1;
      if (fifo_pop)
        rptr <= rptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (load_w) begin
        we_q    <= 1'b1;
        wdata_q <= fifo_empty ? enc : fifo[rptr];
      end else if (wr_done) begin
        we_q <= 1'b0;
      end

      if (start_acc) begin
        addr_q     <= BASE_ADDR;
        word_count <= '0;
      end else if (wr_done) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (word_count != 16'hFFFF)
          word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder: default 64-bit instance plus a
// 4-bit-address instance (BASE_ADDR=12) for address wrap and start/load_end priority.
module tb_rv_instr_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, load_end = 1'b0, start2 = 1'b0, load_end2 = 1'b0;
  logic busy, done, err, busy2, done2, err2;
  logic [15:0] word_count, word_count2;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_addr;
  int exp_wc;
  int writes;

  always #5 clk = ~clk;

  rv_instr_encoder_if #(.ADDR_W(64)) bus1 ();
  rv_instr_encoder_if #(.ADDR_W(4))  bus2 ();

  rv_instr_encoder #(.ADDR_W(64), .BASE_ADDR(64'd0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .load_end(load_end), .bus(bus1),
    .busy(busy), .done(done), .word_count(word_count), .err(err)
  );

  rv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .load_end(load_end2), .bus(bus2),
    .busy(busy2), .done(done2), .word_count(word_count2), .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set1(input logic [1:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [12:0] imm);
    bus1.req_kind = kind; bus1.req_funct3 = f3; bus1.req_funct7 = f7;
    bus1.req_rd = rd; bus1.req_rs1 = rs1; bus1.req_rs2 = rs2; bus1.req_imm = imm;
  endtask

  task automatic send1(input logic [1:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [12:0] imm);
    int n;
    set1(kind, f3, f7, rd, rs1, rs2, imm);
    bus1.req_valid = 1'b1;
    n = 0;
    while (!bus1.req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", {63'd0, bus1.req_ready}, 64'd1);
    tick();
    bus1.req_valid = 1'b0;
  endtask

  initial begin
    bus1.req_valid = 1'b0; bus1.imem_stall = 1'b0;
    set1(2'b00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    bus2.req_valid = 1'b0; bus2.imem_stall = 1'b0;
    bus2.req_kind = 2'b00; bus2.req_funct3 = 3'd0; bus2.req_funct7 = 7'd0;
    bus2.req_rd = 5'd0; bus2.req_rs1 = 5'd0; bus2.req_rs2 = 5'd0; bus2.req_imm = 13'd0;

    tick(); tick();
    reset = 1'b0;
    chk("rst_we",    {63'd0, bus1.imem_we}, 64'd0);
    chk("rst_addr",  bus1.imem_addr, 64'd0);
    chk("rst_ready", {63'd0, bus1.req_ready}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_wc",    {48'd0, word_count}, 64'd0);
    chk("rst_err",   {63'd0, err}, 64'd0);
    chk("rst_addr2", {60'd0, bus2.imem_addr}, 64'd12);

    // small instance: start wins over load_end, addresses wrap 12 -> 0
    start2 = 1'b1; load_end2 = 1'b1;
    tick();
    start2 = 1'b0; load_end2 = 1'b0;
    chk("d2_busy",  {63'd0, busy2}, 64'd1);
    chk("d2_ready", {63'd0, bus2.req_ready}, 64'd1);
    bus2.req_rd = 5'd1; bus2.req_valid = 1'b1;
    tick();
    bus2.req_rd = 5'd2;
    chk("d2_we0",    {63'd0, bus2.imem_we}, 64'd1);
    chk("d2_addr0",  {60'd0, bus2.imem_addr}, 64'd12);
    chk("d2_wdata0", {32'd0, bus2.imem_wdata}, 64'h0000_00B3);
    tick();
    bus2.req_valid = 1'b0;
    chk("d2_addr1",  {60'd0, bus2.imem_addr}, 64'd0);
    chk("d2_wdata1", {32'd0, bus2.imem_wdata}, 64'h0000_0133);
    tick();
    chk("d2_we_off", {63'd0, bus2.imem_we}, 64'd0);
    chk("d2_wc",     {48'd0, word_count2}, 64'd2);
    chk("d2_addr2",  {60'd0, bus2.imem_addr}, 64'd4);
    load_end2 = 1'b1;
    tick();
    load_end2 = 1'b0;
    tick();
    chk("d2_done", {63'd0, done2}, 64'd1);
    chk("d2_idle", {63'd0, busy2}, 64'd0);

    // main instance: first R-type
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy",  {63'd0, busy}, 64'd1);
    chk("load_ready", {63'd0, bus1.req_ready}, 64'd1);
    send1(2'b00, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    chk("r_we",    {63'd0, bus1.imem_we}, 64'd1);
    chk("r_addr",  bus1.imem_addr, 64'd0);
    chk("r_wdata", {32'd0, bus1.imem_wdata}, 64'h0020_81B3);
    tick();
    chk("r_we_off", {63'd0, bus1.imem_we}, 64'd0);
    chk("r_addr4",  bus1.imem_addr, 64'd4);
    chk("r_wc",     {48'd0, word_count}, 64'd1);

    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    chk("flush_ready", {63'd0, bus1.req_ready}, 64'd0);
    for (int n = 0; n < 20 && !done; n++) tick();
    chk("done1", {63'd0, done}, 64'd1);
    chk("done1_busy", {63'd0, busy}, 64'd0);
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    chk("done_hold", {63'd0, done}, 64'd1);

    // restart clears counters; ld then sd back-to-back
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_wc",   {48'd0, word_count}, 64'd0);
    chk("restart_addr", bus1.imem_addr, 64'd0);
    send1(2'b01, 3'd0, 7'd0, 5'd5, 5'd10, 5'd0, 13'd8);
    chk("ld_addr",  bus1.imem_addr, 64'd0);
    chk("ld_wdata", {32'd0, bus1.imem_wdata}, 64'h0085_3283);
    send1(2'b10, 3'd0, 7'd0, 5'd0, 5'd10, 5'd5, 13'd16);
    chk("sd_we",    {63'd0, bus1.imem_we}, 64'd1);
    chk("sd_addr",  bus1.imem_addr, 64'd4);
    chk("sd_wdata", {32'd0, bus1.imem_wdata}, 64'h0055_3823);
    tick();
    chk("ldsd_wc",   {48'd0, word_count}, 64'd2);
    chk("ldsd_addr", bus1.imem_addr, 64'd8);

    send1(2'b11, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8);
    chk("beq_addr",  bus1.imem_addr, 64'd8);
    chk("beq_wdata", {32'd0, bus1.imem_wdata}, 64'hFE20_8CE3);
    tick();
    exp_addr = 64'd12;
    exp_wc   = 3;

    send1(2'b11, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h0003);
`ifdef RV_ENC_CHECK_EN
    chk("bad_beq_we",  {63'd0, bus1.imem_we}, 64'd0);
    chk("bad_beq_err", {63'd0, err}, 64'd1);
    tick();
    chk("bad_beq_wc", {48'd0, word_count}, 64'(exp_wc));
`else
    chk("odd_beq_wdata", {32'd0, bus1.imem_wdata}, 64'h0020_8163);
    chk("odd_beq_err",   {63'd0, err}, 64'd0);
    tick();
    exp_addr = exp_addr + 64'd4;
    exp_wc   = exp_wc + 1;
    chk("odd_beq_wc", {48'd0, word_count}, 64'(exp_wc));
`endif

    // stalled memory: DEPTH in the FIFO plus one held in the writer
    bus1.imem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set1(2'b00, 3'd0, 7'd0, 5'(16 + i), 5'd0, 5'd0, 13'd0);
      bus1.req_valid = 1'b1;
      tick();
    end
    bus1.req_valid = 1'b0;
    chk("full_ready", {63'd0, bus1.req_ready}, 64'd0);
    chk("stall_we",   {63'd0, bus1.imem_we}, 64'd1);
    chk("stall_addr", bus1.imem_addr, exp_addr);
    tick(); tick();
    chk("stall_hold_addr",  bus1.imem_addr, exp_addr);
    chk("stall_hold_wdata", {32'd0, bus1.imem_wdata}, 64'((16 << 7) | 'h33));
    bus1.imem_stall = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("drain_wdata", {32'd0, bus1.imem_wdata}, 64'(((16 + i) << 7) | 'h33));
      chk("drain_addr",  bus1.imem_addr, exp_addr + 64'(4 * i));
    end
    tick();
    exp_addr = exp_addr + 64'd20;
    exp_wc   = exp_wc + 5;
    chk("drain_we_off", {63'd0, bus1.imem_we}, 64'd0);
    chk("drain_wc",     {48'd0, word_count}, 64'(exp_wc));
    chk("drain_addr_end", bus1.imem_addr, exp_addr);

    // load_end with three words queued behind a stall
    bus1.imem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set1(2'b00, 3'd0, 7'd0, 5'(24 + i), 5'd0, 5'd0, 13'd0);
      bus1.req_valid = 1'b1;
      tick();
    end
    bus1.req_valid = 1'b0;
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    chk("flush3_busy", {63'd0, busy}, 64'd1);
    chk("flush3_done", {63'd0, done}, 64'd0);
    bus1.imem_stall = 1'b0;
    writes = 0;
    for (int n = 0; n < 30 && !done; n++) begin
      if (bus1.imem_we && !bus1.imem_stall) writes++;
      tick();
    end
    chk("flush3_writes", 64'(writes), 64'd3);
    chk("flush3_done_end", {63'd0, done}, 64'd1);
    chk("flush3_busy_end", {63'd0, busy}, 64'd0);
    chk("flush3_wc",   {48'd0, word_count}, 64'(exp_wc + 3));
    chk("flush3_addr", bus1.imem_addr, exp_addr + 64'd12);

    // reset while a write is stalled
    start = 1'b1;
    tick();
    start = 1'b0;
    bus1.imem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set1(2'b01, 3'd0, 7'd0, 5'(i + 1), 5'd2, 5'd0, 13'd4);
      bus1.req_valid = 1'b1;
      tick();
    end
    bus1.req_valid = 1'b0;
    chk("pre_rst_we", {63'd0, bus1.imem_we}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_we",    {63'd0, bus1.imem_we}, 64'd0);
    chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus1.req_ready}, 64'd0);
    chk("mid_rst_addr",  bus1.imem_addr, 64'd0);
    chk("mid_rst_wc",    {48'd0, word_count}, 64'd0);
    bus1.imem_stall = 1'b0;
    tick(); tick();
    chk("post_rst_we", {63'd0, bus1.imem_we}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
